// File: rtl/fetch_unit.sv
// fetch_unit: fetches the instruction at pc into a DEPTH-entry {pc,instr} FIFO; optional perf counters under FETCH_PERF_EN.
// Latency 2 cycles per instruction on zero-wait memory (req, ack); fetch stalls while the FIFO is full, pops on instr_valid & instr_ready.
module fetch_unit #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] IMEM_LIMIT = 16'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  output logic [15:0] pc_next,
  output logic        pc_en,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        imem_err,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [1:0]  fault_code,
  output logic [15:0] fault_epc,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD, S_FAULT} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  state_t        state, state_nxt;
  logic [1:0]    code_nxt;
  logic [15:0]   epc_nxt;
  logic          push, pop, flush;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  entry_t        mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // A redirect in IDLE suppresses both the fault check and the request for that cycle.
  always_comb begin
    state_nxt = state;
    code_nxt  = 2'b00;
    epc_nxt   = pc;
    case (state)
      S_IDLE: if (!redirect_valid) begin
        if (pc[0]) begin
          state_nxt = S_FAULT;
          code_nxt  = 2'b01;
        end else if (pc >= IMEM_LIMIT) begin
          state_nxt = S_FAULT;
          code_nxt  = 2'b10;
        end else if (count != FULL) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: if (redirect_valid) begin
        state_nxt = imem_ack ? S_IDLE : S_DISCARD;
      end else if (imem_ack) begin
        if (imem_err) begin
          state_nxt = S_FAULT;
          code_nxt  = 2'b11;
          epc_nxt   = imem_addr;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DISCARD: if (imem_ack) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en    = (state != S_FAULT);
    imem_req = (state == S_WAIT) || (state == S_DISCARD);
    pc_next  = pc;
    push     = 1'b0;
    flush    = 1'b0;
    if (state == S_FAULT) begin
      flush = 1'b1;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
      flush   = 1'b1;
    end else if (state == S_WAIT && imem_ack && !imem_err) begin
      push    = 1'b1;
      pc_next = imem_addr + 16'd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_addr  <= '0;
      fault_code <= 2'b00;
      fault_epc  <= '0;
    end else begin
      if (state == S_IDLE && state_nxt == S_WAIT) imem_addr <= pc;
      if (state != S_FAULT && state_nxt == S_FAULT) begin
        fault_code <= code_nxt;
        fault_epc  <= epc_nxt;
      end
    end
  end

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? mem[rd_ptr].instr : 16'h0;
  assign instr_pc    = instr_valid ? mem[rd_ptr].pc    : 16'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: imem_addr, instr: imem_rdata};
  end

`ifdef FETCH_PERF_EN
  logic        stall;
  logic [15:0] fetch_cnt, stall_cnt;

  assign stall = (state == S_IDLE) && !redirect_valid && !pc[0] &&
                 (pc < IMEM_LIMIT) && (count == FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push  && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = 16'h0;
  assign perf_stall_cnt = 16'h0;
`endif

endmodule
